// File: rtl/pn9_chk_pkg.sv
// Shared types and helpers for the PN9 (x^9+x^5+1) receive checker.
//   pn9_state_e  : checker FSM states
//   pn9_adv_t    : result of advancing a 9-bit PN9 history by N bits
//   pn9_advance  : unroll b[n] = b[n-9] ^ b[n-5] for N steps (msb-justified output)
//   popcount16   : number of set bits in a 16-bit vector
package pn9_chk_pkg;

  typedef enum logic [0:0] {
    SEARCH = 1'b0,
    LOCKED = 1'b1
  } pn9_state_e;

  localparam int unsigned N16      = 16;
  localparam int unsigned N14      = 14;
  localparam int unsigned WORD_W   = 16;
  localparam int unsigned HIST_W   = 9;
  localparam int unsigned WERR_W   = 5;
  localparam int unsigned SCNT_W   = 4;
  localparam logic [HIST_W-1:0] HIST_RST = 9'h1FF;

  typedef struct packed {
    logic [WORD_W-1:0] bits;
    logic [HIST_W-1:0] hist;
  } pn9_adv_t;

  // hist[0] is the newest bit, so b[n-9] = hist[8] and b[n-5] = hist[4].
  function automatic pn9_adv_t pn9_advance(input logic [HIST_W-1:0] hist,
                                           input int unsigned n);
    pn9_adv_t          res;
    logic [HIST_W-1:0] h;
    logic              nb;
    res.bits = '0;
    h        = hist;
    for (int unsigned i = 0; i < WORD_W; i++) begin
      if (i < n) begin
        nb                     = h[8] ^ h[4];
        res.bits[4'(15 - i)]   = nb;
        h                      = {h[HIST_W-2:0], nb};
      end
    end
    res.hist = h;
    return res;
  endfunction

  function automatic logic [WERR_W-1:0] popcount16(input logic [WORD_W-1:0] v);
    logic [WERR_W-1:0] c;
    c = '0;
    for (int unsigned i = 0; i < WORD_W; i++) begin
      c = c + {4'b0000, v[i]};
    end
    return c;
  endfunction

endpackage

// File: rtl/pn9_checker_if.sv
// Stream/control/status bundle between a PN9 source and pn9_checker.
//   master : drives enable, mode, in_valid, in_data, clear; observes status
//   slave  : the checker side
interface pn9_checker_if #(
  parameter int unsigned CNT_W = 32
) ();
  logic             enable;
  logic             mode;
  logic             in_valid;
  logic [15:0]      in_data;
  logic             clear;
  logic             locked;
  logic [4:0]       word_err;
  logic             err_valid;
  logic [CNT_W-1:0] err_cnt;
  logic [CNT_W-1:0] bit_cnt;
  logic             sat;

  modport master (
    output enable, mode, in_valid, in_data, clear,
    input  locked, word_err, err_valid, err_cnt, bit_cnt, sat
  );

  modport slave (
    input  enable, mode, in_valid, in_data, clear,
    output locked, word_err, err_valid, err_cnt, bit_cnt, sat
  );
endinterface

// File: rtl/pn9_chk_expect.sv
// Combinational PN9 predictor: expected word, valid-bit mask and the
// history that results from consuming the word.
//   i_hist        : newest 9 stream bits, bit 0 newest
//   i_mode        : 1 = 16 bits per word, 0 = 14 bits in [15:2]
//   o_expected_c  : predicted msb-justified word
//   o_mask_c      : ones on the valid bit positions
//   o_next_hist_c : history after the predicted word
module pn9_chk_expect
  import pn9_chk_pkg::*;
(
  input  logic [HIST_W-1:0] i_hist,
  input  logic              i_mode,
  output logic [WORD_W-1:0] o_expected_c,
  output logic [WORD_W-1:0] o_mask_c,
  output logic [HIST_W-1:0] o_next_hist_c
);

  pn9_adv_t w_adv16;
  pn9_adv_t w_adv14;

  assign w_adv16 = pn9_advance(i_hist, N16);
  assign w_adv14 = pn9_advance(i_hist, N14);

  assign o_expected_c  = i_mode ? w_adv16.bits : w_adv14.bits;
  assign o_next_hist_c = i_mode ? w_adv16.hist : w_adv14.hist;
  assign o_mask_c      = i_mode ? 16'hFFFF : 16'hFFFC;

endmodule

// File: rtl/pn9_checker.sv
// PN9 receive checker: self-synchronises to the incoming stream, then
// flywheels its own prediction and counts bit errors / checked bits.
//   clk, resetb : clock, asynchronous active-low reset
//   bus (slave) : enable, mode, in_valid, in_data, clear in;
//                 locked, word_err, err_valid, err_cnt, bit_cnt, sat out
module pn9_checker
  import pn9_chk_pkg::*;
#(
  parameter int unsigned LOCK_CNT   = 4,
  parameter int unsigned LOSS_CNT   = 4,
  parameter int unsigned ERR_THRESH = 2,
  parameter int unsigned CNT_W      = 32
) (
  input  logic          clk,
  input  logic          resetb,
  pn9_checker_if.slave  bus
);

  localparam int unsigned      SUM_W     = CNT_W + 1;
  localparam logic [0:0]       ST_SEARCH = SEARCH;
  localparam logic [0:0]       ST_LOCKED = LOCKED;
  localparam logic [SUM_W-1:0] SUM_MAX   = {1'b0, {CNT_W{1'b1}}};

  logic [0:0]        r_state,     w_state_nxt;
  logic [HIST_W-1:0] r_hist,      w_hist_nxt;
  logic              r_seeded,    w_seeded_nxt;
  logic              r_mode,      w_mode_nxt;
  logic [SCNT_W-1:0] r_match,     w_match_nxt;
  logic [SCNT_W-1:0] r_bad,       w_bad_nxt;
  logic              r_locked,    w_locked_nxt;
  logic [WERR_W-1:0] r_word_err,  w_word_err_nxt;
  logic              r_err_valid, w_err_valid_nxt;
  logic [CNT_W-1:0]  r_err_cnt,   w_err_cnt_nxt;
  logic [CNT_W-1:0]  r_bit_cnt,   w_bit_cnt_nxt;
  logic              r_sat,       w_sat_nxt;

  logic [WORD_W-1:0] w_expected;
  logic [WORD_W-1:0] w_mask;
  logic [HIST_W-1:0] w_next_hist;
  logic [WERR_W-1:0] w_weight;
  logic [WERR_W-1:0] w_n;
  logic [HIST_W-1:0] w_rx_hist;
  logic              w_reseed;
  logic              w_accum;
  logic [SUM_W-1:0]  w_err_sum;
  logic [SUM_W-1:0]  w_bit_sum;

  pn9_chk_expect u_expect (
    .i_hist        (r_hist),
    .i_mode        (bus.mode),
    .o_expected_c  (w_expected),
    .o_mask_c      (w_mask),
    .o_next_hist_c (w_next_hist)
  );

  // Per-word error weight and the last 9 received bits (reseed source).
  assign w_weight  = popcount16((bus.in_data ^ w_expected) & w_mask);
  assign w_n       = bus.mode ? WERR_W'(N16) : WERR_W'(N14);
  assign w_rx_hist = bus.mode ? bus.in_data[8:0] : bus.in_data[10:2];

  // A word of a different width invalidates the current alignment.
  assign w_reseed  = !r_seeded || (bus.mode != r_mode);
  assign w_accum   = bus.enable && bus.in_valid && !w_reseed && (r_state == ST_LOCKED);

  assign w_err_sum = {1'b0, r_err_cnt} + SUM_W'(w_weight);
  assign w_bit_sum = {1'b0, r_bit_cnt} + SUM_W'(w_n);

  // Next-state, history, sync counters and accumulators.
  always_comb begin
    w_state_nxt     = r_state;
    w_hist_nxt      = r_hist;
    w_seeded_nxt    = r_seeded;
    w_mode_nxt      = r_mode;
    w_match_nxt     = r_match;
    w_bad_nxt       = r_bad;
    w_word_err_nxt  = r_word_err;
    w_err_valid_nxt = 1'b0;
    w_err_cnt_nxt   = r_err_cnt;
    w_bit_cnt_nxt   = r_bit_cnt;
    w_sat_nxt       = r_sat;

    if (!bus.enable) begin
      w_state_nxt  = ST_SEARCH;
      w_seeded_nxt = 1'b0;
      w_hist_nxt   = HIST_RST;
      w_match_nxt  = '0;
      w_bad_nxt    = '0;
    end else if (bus.in_valid) begin
      w_mode_nxt = bus.mode;
      if (w_reseed) begin
        w_state_nxt  = ST_SEARCH;
        w_hist_nxt   = w_rx_hist;
        w_seeded_nxt = 1'b1;
        w_match_nxt  = '0;
        w_bad_nxt    = '0;
      end else if (r_state == ST_SEARCH) begin
        w_hist_nxt = w_rx_hist;
        if (w_weight == '0) begin
          if (({1'b0, r_match} + 5'd1) == 5'(LOCK_CNT)) begin
            w_state_nxt = ST_LOCKED;
            w_match_nxt = '0;
            w_bad_nxt   = '0;
          end else begin
            w_match_nxt = r_match + 4'd1;
          end
        end else begin
          w_match_nxt = '0;
        end
      end else begin
        // Flywheel: the prediction never absorbs received errors.
        w_hist_nxt      = w_next_hist;
        w_err_valid_nxt = 1'b1;
        w_word_err_nxt  = w_weight;
        if (w_weight > 5'(ERR_THRESH)) begin
          if (({1'b0, r_bad} + 5'd1) == 5'(LOSS_CNT)) begin
            w_state_nxt  = ST_SEARCH;
            w_seeded_nxt = 1'b0;
            w_bad_nxt    = '0;
            w_match_nxt  = '0;
          end else begin
            w_bad_nxt = r_bad + 4'd1;
          end
        end else begin
          w_bad_nxt = '0;
        end
      end
    end

    // Clear beats accumulate; the accumulating word's value still lands.
    if (bus.clear) begin
      w_err_cnt_nxt = w_accum ? CNT_W'(w_weight) : '0;
      w_bit_cnt_nxt = w_accum ? CNT_W'(w_n)      : '0;
      w_sat_nxt     = 1'b0;
    end else if (w_accum) begin
      w_err_cnt_nxt = (w_err_sum >= SUM_MAX) ? '1 : w_err_sum[CNT_W-1:0];
      w_bit_cnt_nxt = (w_bit_sum >= SUM_MAX) ? '1 : w_bit_sum[CNT_W-1:0];
      w_sat_nxt     = r_sat || (w_err_sum >= SUM_MAX) || (w_bit_sum >= SUM_MAX);
    end
  end

  assign w_locked_nxt = (w_state_nxt == ST_LOCKED);

  // State and output registers.
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      r_state     <= ST_SEARCH;
      r_hist      <= HIST_RST;
      r_seeded    <= 1'b0;
      r_mode      <= 1'b1;
      r_match     <= '0;
      r_bad       <= '0;
      r_locked    <= 1'b0;
      r_word_err  <= '0;
      r_err_valid <= 1'b0;
      r_err_cnt   <= '0;
      r_bit_cnt   <= '0;
      r_sat       <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_hist      <= w_hist_nxt;
      r_seeded    <= w_seeded_nxt;
      r_mode      <= w_mode_nxt;
      r_match     <= w_match_nxt;
      r_bad       <= w_bad_nxt;
      r_locked    <= w_locked_nxt;
      r_word_err  <= w_word_err_nxt;
      r_err_valid <= w_err_valid_nxt;
      r_err_cnt   <= w_err_cnt_nxt;
      r_bit_cnt   <= w_bit_cnt_nxt;
      r_sat       <= w_sat_nxt;
    end
  end

  assign bus.locked    = r_locked;
  assign bus.word_err  = r_word_err;
  assign bus.err_valid = r_err_valid;
  assign bus.err_cnt   = r_err_cnt;
  assign bus.bit_cnt   = r_bit_cnt;
  assign bus.sat       = r_sat;

endmodule

// File: tb/tb_pn9_checker.sv
// Bench for pn9_checker (8-bit accumulators so saturation is reachable).
// A bit-level PN9 source and a bit-level checker model run alongside the DUT.
module tb_pn9_checker;

  localparam int unsigned CW   = 8;
  localparam int          CMAX = 255;

  logic clk = 1'b0;
  logic resetb;
  always #5 clk = ~clk;

  pn9_checker_if #(.CNT_W(CW)) bus ();

  pn9_checker #(
    .LOCK_CNT(4), .LOSS_CNT(4), .ERR_THRESH(2), .CNT_W(CW)
  ) dut (
    .clk    (clk),
    .resetb (resetb),
    .bus    (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
  endtask

  // ---------------- source: consecutive PN9 bits, oldest at q[0] ----------
  bit g_q[$];

  function automatic logic [15:0] gen_word(input int n, input logic [1:0] pad);
    logic [15:0] wd;
    bit nb;
    wd = '0;
    for (int i = 0; i < n; i++) begin
      nb = g_q[0] ^ g_q[4];
      g_q.push_back(nb);
      void'(g_q.pop_front());
      wd[15-i] = nb;
    end
    if (n == 14) wd[1:0] = pad;
    return wd;
  endfunction

  // ---------------- reference model --------------------------------------
  bit m_hist[$];
  int m_locked, m_seeded, m_match, m_bad, m_mode, m_werr, m_evalid;
  int m_err, m_bits, m_sat;

  task automatic model_reset();
    m_hist = {};
    for (int i = 0; i < 9; i++) m_hist.push_back(1'b1);
    m_locked = 0; m_seeded = 0; m_match = 0; m_bad = 0; m_mode = 1;
    m_werr = 0; m_evalid = 0; m_err = 0; m_bits = 0; m_sat = 0;
  endtask

  task automatic model_clock();
    int  n, w;
    bit  acc;
    bit  p[$];
    bit  rx[$];
    bit  nb;
    acc = 0; w = 0;
    n = bus.mode ? 16 : 14;
    m_evalid = 0;
    if (!bus.enable) begin
      model_reset_sync();
    end else if (bus.in_valid) begin
      p = m_hist;
      for (int i = 0; i < n; i++) begin
        nb = p[0] ^ p[4];
        p.push_back(nb);
        void'(p.pop_front());
        if (bus.in_data[15-i] != nb) w++;
      end
      for (int i = n - 9; i < n; i++) rx.push_back(bus.in_data[15-i]);
      if (!m_seeded || (int'(bus.mode) != m_mode)) begin
        m_locked = 0; m_hist = rx; m_seeded = 1; m_match = 0; m_bad = 0;
      end else if (!m_locked) begin
        m_hist  = rx;
        m_match = (w == 0) ? m_match + 1 : 0;
        if (m_match == 4) begin m_locked = 1; m_bad = 0; m_match = 0; end
      end else begin
        acc = 1;
        m_hist = p; m_evalid = 1; m_werr = w;
        m_bad = (w > 2) ? m_bad + 1 : 0;
        if (m_bad == 4) begin m_locked = 0; m_seeded = 0; m_bad = 0; m_match = 0; end
      end
      m_mode = bus.mode;
    end
    if (bus.clear) begin
      m_err = acc ? w : 0; m_bits = acc ? n : 0; m_sat = 0;
    end else if (acc) begin
      m_err  += w;
      m_bits += n;
      if (m_err >= CMAX)  begin m_err  = CMAX; m_sat = 1; end
      if (m_bits >= CMAX) begin m_bits = CMAX; m_sat = 1; end
    end
  endtask

  task automatic model_reset_sync();
    m_hist = {};
    for (int i = 0; i < 9; i++) m_hist.push_back(1'b1);
    m_locked = 0; m_seeded = 0; m_match = 0; m_bad = 0;
  endtask

  task automatic compare_all();
    chk("locked",    bus.locked,    m_locked);
    chk("err_valid", bus.err_valid, m_evalid);
    chk("err_cnt",   bus.err_cnt,   m_err);
    chk("bit_cnt",   bus.bit_cnt,   m_bits);
    chk("sat",       bus.sat,       m_sat);
    if (m_evalid != 0) chk("word_err", bus.word_err, m_werr);
  endtask

  // One clock: model sees the same inputs as the DUT, outputs sampled #1 later.
  task automatic step();
    @(posedge clk);
    model_clock();
    #1;
    compare_all();
  endtask

  task automatic send(input logic [15:0] d);
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    step();
    bus.in_valid = 1'b0;
  endtask

  task automatic idle();
    bus.in_valid = 1'b0;
    step();
  endtask

  task automatic send_gen(input logic [15:0] flip);
    send(gen_word(bus.mode ? 16 : 14, 2'b11) ^ flip);
  endtask

  int nflip;
  logic [15:0] fm;

  initial begin
    for (int i = 0; i < 9; i++) g_q.push_back(1'b1);
    model_reset();
    resetb = 1'b0;
    bus.enable = 1'b1; bus.mode = 1'b1; bus.in_valid = 1'b0;
    bus.in_data = '0;  bus.clear = 1'b0;
    #22;
    chk("rst_locked", bus.locked, 0);
    chk("rst_evalid", bus.err_valid, 0);
    chk("rst_werr",   bus.word_err, 0);
    chk("rst_errcnt", bus.err_cnt, 0);
    chk("rst_bitcnt", bus.bit_cnt, 0);
    chk("rst_sat",    bus.sat, 0);
    resetb = 1'b1;

    // Clean lock, 16-bit words: seed + 4 matching words.
    for (int k = 1; k <= 5; k++) begin
      send_gen('0);
      chk("lock16", bus.locked, (k == 5) ? 1 : 0);
    end
    chk("lock16_noev", bus.err_valid, 0);
    send_gen('0);
    chk("l16_ev", bus.err_valid, 1);
    chk("l16_werr", bus.word_err, 0);
    chk("l16_bits1", bus.bit_cnt, 16);
    send_gen('0);
    chk("l16_bits2", bus.bit_cnt, 32);

    // Single-bit error; flywheel keeps the next word clean.
    send_gen(16'h0080);
    chk("inj_werr", bus.word_err, 1);
    chk("inj_errcnt", bus.err_cnt, 1);
    chk("inj_locked", bus.locked, 1);
    send_gen('0);
    chk("inj_next", bus.word_err, 0);

    // Clear on an idle cycle, then loss of sync with 3-bit error words.
    bus.clear = 1'b1; idle(); bus.clear = 1'b0;
    chk("clr_err", bus.err_cnt, 0);
    chk("clr_bits", bus.bit_cnt, 0);
    for (int k = 1; k <= 4; k++) begin
      send_gen(16'h0421);
      chk("loss_locked", bus.locked, (k == 4) ? 0 : 1);
    end
    chk("loss_err", bus.err_cnt, 12);
    for (int k = 1; k <= 5; k++) begin
      send_gen('0);
      chk("relock", bus.locked, (k == 5) ? 1 : 0);
    end

    // 14-bit mode: the mode change reseeds.
    bus.mode = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      send_gen('0);
      chk("lock14", bus.locked, (k == 5) ? 1 : 0);
    end
    bus.clear = 1'b1; idle(); bus.clear = 1'b0;
    send_gen('0);
    chk("m14_bits1", bus.bit_cnt, 14);
    chk("m14_werr", bus.word_err, 0);
    send_gen('0);
    chk("m14_bits2", bus.bit_cnt, 28);

    // Enable pulse while locked.
    bus.enable = 1'b0; idle(); bus.enable = 1'b1;
    chk("en_locked", bus.locked, 0);
    chk("en_bits_held", bus.bit_cnt, 28);
    for (int k = 1; k <= 5; k++) begin
      send_gen('0);
      chk("en_relock", bus.locked, (k == 5) ? 1 : 0);
    end

    // Mode toggle while locked.
    bus.mode = 1'b1;
    send_gen('0);
    chk("tog_locked", bus.locked, 0);
    chk("tog_bits_held", bus.bit_cnt, 28);
    for (int k = 1; k <= 4; k++) send_gen('0);
    chk("tog_relock", bus.locked, 1);

    // Saturation: alternate all-bit-error and clean words.
    bus.clear = 1'b1; idle(); bus.clear = 1'b0;
    for (int k = 0; k < 40; k++) send_gen((k % 2 == 0) ? 16'hFFFF : 16'h0000);
    chk("sat_err", bus.err_cnt, CMAX);
    chk("sat_bits", bus.bit_cnt, CMAX);
    chk("sat_flag", bus.sat, 1);
    bus.clear = 1'b1; send_gen(16'h0007); bus.clear = 1'b0;
    chk("clracc_err", bus.err_cnt, 3);
    chk("clracc_bits", bus.bit_cnt, 16);
    chk("clracc_sat", bus.sat, 0);
    chk("clracc_werr", bus.word_err, 3);

    // Asynchronous reset in the middle of a cycle.
    send_gen('0);
    #3 resetb = 1'b0;
    #1;
    chk("arst_locked", bus.locked, 0);
    chk("arst_err", bus.err_cnt, 0);
    chk("arst_bits", bus.bit_cnt, 0);
    chk("arst_evalid", bus.err_valid, 0);
    model_reset();
    #2 resetb = 1'b1;

    // Randomised stream: gaps, error bursts, slips, mode/enable/clear events.
    for (int c = 0; c < 3000; c++) begin
      bus.enable = ($urandom_range(0, 99) != 0);
      bus.clear  = bus.enable && ($urandom_range(0, 99) < 3);
      if ($urandom_range(0, 199) == 0) bus.mode = ~bus.mode;
      if ($urandom_range(0, 149) == 0) begin
        nflip = $urandom_range(1, 20);
        for (int s = 0; s < nflip; s++) void'(gen_word(1, 2'b00));
      end
      if ($urandom_range(0, 99) < 85) begin
        case ($urandom_range(0, 9))
          0:       fm = 16'h0001 << $urandom_range(0, 15);
          1:       fm = 16'($urandom);
          default: fm = '0;
        endcase
        bus.in_valid = 1'b1;
        bus.in_data  = gen_word(bus.mode ? 16 : 14, 2'($urandom)) ^ fm;
      end else begin
        bus.in_valid = 1'b0;
        bus.in_data  = 16'($urandom);
      end
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/pn9_checker.md
Name: pn9_checker

Overview:
- Receive-side companion to the 16/14-bit-per-clock PN9 generator (CCITT O.153, x^9+x^5+1); sits directly downstream of the datapath under test.
- Consumes msb-justified words and self-synchronises its own PN9 history from the incoming stream.
- Once locked, counts bit errors and received bits, and reports per-word error weight for BER measurement.
- Detects loss of sync and re-acquires automatically.

Parameters:
- LOCK_CNT, 4, consecutive error-free words required in SEARCH to declare lock (1..15).
- LOSS_CNT, 4, consecutive "bad" words in LOCKED before dropping to SEARCH (1..15).
- ERR_THRESH, 2, a word is "bad" when its bit-error count exceeds this value (0..15).
- CNT_W, 32, width of the err_cnt and bit_cnt accumulators.

Ports:
- clk  input  1  clock
- resetb  input  1  asynchronous active-low reset
- enable  input  1  0 forces SEARCH and clears the history; counters are held
- mode  input  1  1 = 16 valid bits per word; 0 = 14 valid bits in in_data[15:2], with [1:0] ignored
- in_valid  input  1  in_data is valid this cycle
- in_data  input  16  msb-justified PN9 word
- clear  input  1  synchronous clear of err_cnt, bit_cnt and the sat flag
- locked  output  1  checker is in LOCKED state
- word_err  output  5  error weight of the last checked word (0..16)
- err_valid  output  1  word_err / counters were updated by the last word
- err_cnt  output  CNT_W  accumulated bit errors since the last clear, saturating
- bit_cnt  output  CNT_W  accumulated bits checked since the last clear, saturating
- sat  output  1  sticky flag: either accumulator has saturated

Behaviour:
- Reset:
  - resetb is asynchronous, active-low; clock is clk.
  - On reset: state=SEARCH, hist=9'h1FF, seeded=0, match/bad counters=0, locked=0, word_err=0, err_valid=0, err_cnt=0, bit_cnt=0, sat=0.
- Stream definition:
  - in_data[15] is the oldest bit in time. Each word carries the next N consecutive bits, N=16 (mode=1) or 14 (mode=0).
  - Recurrence: b[n] = b[n-9] XOR b[n-5].
  - hist holds the newest 9 bits, with hist[0] the newest.
- Expected word: computed combinationally by unrolling the recurrence N steps from hist; the last 9 bits produced form next_hist_exp.
- Per in_valid cycle, with enable=1:
  - errv = in_data XOR expected, masked to the N valid bits.
  - w = popcount(errv).
- SEARCH:
  - seeded=0: load hist from the last 9 received bits (in_data[8:0] for mode=1; in_data[10:2] for mode=0), set seeded=1, match=0. No error output.
  - seeded=1: if w==0, match++, else match=0. hist is always reloaded from the received bits.
  - When match reaches LOCK_CNT: go to LOCKED, bad=0.
  - err_valid stays 0 and counters do not change in SEARCH.
- LOCKED:
  - hist <= next_hist_exp (flywheel), so received errors never corrupt the prediction.
  - err_valid=1 and word_err=w, both registered one clock after the in_valid cycle.
  - err_cnt += w and bit_cnt += N, each saturating at all-ones; sat is set on saturation.
  - If w > ERR_THRESH: bad++, else bad=0. When bad reaches LOSS_CNT: go to SEARCH with seeded=0.
- Outputs: single-cycle latency. locked changes on the clock edge that samples the qualifying word. err_valid is low on cycles without in_valid.
- Boundary cases:
  - mode changes between valid words: go to SEARCH, seeded=0, match=0; that word is treated as the first seed word.
  - enable=0: go to SEARCH, seeded=0, hist=9'h1FF. err_cnt, bit_cnt and sat are held.
  - clear together with an accumulate: clear wins, and the accumulator loads the current word's value (err_cnt=w, bit_cnt=N).
  - in_valid=0: full state hold.
  - Reset mid-word: all state returns immediately to its reset values.

Decomposition:
- Package pn9_chk_pkg holds:
  - the state enum (SEARCH, LOCKED);
  - localparams N16=16 and N14=14;
  - function pn9_advance(hist, n) returning the expected bits and next hist;
  - function popcount16.
- One natural sub-module, pn9_chk_expect: purely combinational; takes hist and mode; produces expected[15:0], valid mask[15:0] and next_hist_exp[8:0]. The top module holds the FSM and the accumulators.

Test Plan:
- Clean lock, mode=1: generator model seeded with all-ones feeds consecutive words → locked=1 on the edge of valid word 5 (1 seed + LOCK_CNT=4); afterwards word_err=0 and bit_cnt increments by 16 per word.
- Single-bit injection while locked: flip in_data[7] in one word → word_err=1, err_cnt=1, locked stays 1, and the next word shows word_err=0 (flywheel not corrupted).
- Loss of sync: 4 consecutive words with 3 flipped bits each → err_cnt=12, locked=0 after the 4th word; then a clean stream re-locks after 5 more words.
- mode=0 path: 14-bit words with in_data[1:0] driven to 2'b11 → locked after 5 words, word_err=0, bit_cnt increments by 14 per word.
- Mode toggle and enable: toggling mode mid-stream, or pulsing enable=0 while locked, → locked=0 next cycle, counters held, re-lock after 5 words.
- Saturation and clear: preload err_cnt near max (CNT_W=8 build) and inject errors → err_cnt=8'hFF and sat=1. Asserting clear alongside an error word gives err_cnt=w and sat=0.
